seq_mul_add: RTL and testbench

- Sequential shift-add multiply-accumulate: computes p = a * b + c, one multiplier bit per clock.
- Inverse of our binary divider: feed it quotient, divisor and remainder and it rebuilds the dividend.
- Used to check divider results and for scaling by constants where a combinational multiplier costs too much area.
- Start/busy/done handshake toward a controlling FSM.

---
 rtl/seq_mul_add_pkg.sv | 16 +
 rtl/seq_mul_add.sv | 92 +++++++++
 tb/tb_seq_mul_add.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_mul_add_pkg.sv
// Shared definitions for the shift-add multiply-accumulate and its divider siblings:
// FSM state encoding and the iteration counter width rule.
package seq_mul_add_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Counter must hold WIDTH_B itself, hence the +1.
   function automatic int cnt_width(input int width_b);
      return $clog2(width_b + 1);
   endfunction

endpackage

// File: rtl/seq_mul_add.sv
// Sequential p = a*b + c, one multiplier bit per clock; rebuilds a dividend from
// quotient, divisor and remainder. Fixed latency of WIDTH_B RUN cycles.
module seq_mul_add
   import seq_mul_add_pkg::*;
#(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH_A-1:0]         a,
   input  logic [WIDTH_B-1:0]         b,
   input  logic [WIDTH_B-1:0]         c,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH_A+WIDTH_B-1:0] p
);

   localparam int PW = WIDTH_A + WIDTH_B;
   localparam int CW = cnt_width(WIDTH_B);

   state_e          state_q, state_d;
   logic [PW-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH_B-1:0] b_sh_q, b_sh_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   p_q, p_d;
   logic [PW-1:0]   acc_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      acc_sum = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = PW'(a);
               b_sh_d  = b;
               acc_d   = PW'(c);
               cnt_d   = CW'(WIDTH_B);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d  = acc_sum;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q - CW'(1);
            // Last multiplier bit: publish the sum that includes it.
            if (cnt_q == CW'(1)) begin
               p_d     = acc_sum;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign p    = p_q;

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed checks of seq_mul_add (8x4) plus a 12x4 divider round-trip.
module tb_seq_mul_add;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [3:0]  b = '0;
   logic [3:0]  c = '0;
   logic        busy, done;
   logic [11:0] p;

   logic        start2 = 1'b0;
   logic [11:0] a2 = '0;
   logic [3:0]  b2 = '0;
   logic [3:0]  c2 = '0;
   logic        busy2, done2;
   logic [15:0] p2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_mul_add #(.WIDTH_A(8), .WIDTH_B(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
      .busy(busy), .done(done), .p(p)
   );

   seq_mul_add #(.WIDTH_A(12), .WIDTH_B(4)) dut_rt (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2),
      .busy(busy2), .done(done2), .p(p2)
   );

   // Stimulus driver only: runs one operation and reports what was observed.
   task automatic do_op(input logic [7:0] ia, input logic [3:0] ib, input logic [3:0] ic,
                        output int nbusy, output int ndone, output int done_at,
                        output logic [11:0] pres, output logic both, output logic p_moved);
      logic [11:0] p_before;
      nbusy = 0; ndone = 0; done_at = -1; pres = '0; both = 1'b0; p_moved = 1'b0;
      @(negedge clk);
      a = ia; b = ib; c = ic; start = 1'b1;
      p_before = p;
      @(negedge clk);
      start = 1'b0;
      a = ~ia; b = ~ib; c = ~ic;
      for (int k = 0; k < 12; k++) begin
         if (busy) nbusy++;
         if (busy && done) both = 1'b1;
         if (done) begin
            ndone++;
            done_at = k;
            pres = p;
         end else if (ndone == 0 && p !== p_before) begin
            p_moved = 1'b1;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (p !== 12'd0) begin failures++; $display("FAIL reset_p got=%0d exp=0", p); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      $display("test_reset: busy=%b done=%b p=%0d", busy, done, p);
   endtask

   task automatic test_basic();
      int nb, nd, da; logic [11:0] pr; logic bo, pm;
      do_op(8'd200, 4'd13, 4'd7, nb, nd, da, pr, bo, pm);
      checks++; if (nb != 4) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=4", nb); end
      checks++; if (nd != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
      checks++; if (da != 4) begin failures++; $display("FAIL basic_done_pos got=%0d exp=4", da); end
      checks++; if (pr !== 12'd2607) begin failures++; $display("FAIL basic_p got=%0d exp=2607", pr); end
      checks++; if (pm !== 1'b0) begin failures++; $display("FAIL basic_p_stable_in_run got=%b exp=0", pm); end
      checks++; if (bo !== 1'b0) begin failures++; $display("FAIL basic_busy_and_done got=%b exp=0", bo); end
      $display("test_basic: 200*13+7 p=%0d busy_cycles=%0d done_at=%0d", pr, nb, da);
   endtask

   task automatic test_extremes();
      logic [7:0]  ta [3] = '{8'd255, 8'd0, 8'd77};
      logic [3:0]  tb [3] = '{4'd15, 4'd9, 4'd0};
      logic [3:0]  tc [3] = '{4'd15, 4'd5, 4'd0};
      logic [11:0] te [3] = '{12'd3840, 12'd5, 12'd0};
      int nb, nd, da; logic [11:0] pr; logic bo, pm;
      for (int i = 0; i < 3; i++) begin
         do_op(ta[i], tb[i], tc[i], nb, nd, da, pr, bo, pm);
         checks++; if (pr !== te[i]) begin failures++; $display("FAIL extreme_p[%0d] got=%0d exp=%0d", i, pr, te[i]); end
         checks++; if (da != 4 || nb != 4 || nd != 1) begin failures++; $display("FAIL extreme_latency[%0d] got done_at=%0d busy=%0d ndone=%0d exp 4/4/1", i, da, nb, nd); end
         $display("test_extremes: %0d*%0d+%0d p=%0d done_at=%0d", ta[i], tb[i], tc[i], pr, da);
      end
   endtask

   task automatic test_ignore_start();
      int nd; logic [11:0] pr;
      nd = 0; pr = '0;
      @(negedge clk);
      a = 8'd200; b = 4'd13; c = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (k == 1) begin a = 8'd1; b = 4'd1; c = 4'd0; start = 1'b1; end
         else start = 1'b0;
         if (done) begin nd++; pr = p; end
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (nd != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
      checks++; if (pr !== 12'd2607) begin failures++; $display("FAIL ignore_p got=%0d exp=2607", pr); end
      $display("test_ignore_start: p=%0d dones=%0d", pr, nd);
   endtask

   task automatic test_reset_mid_run();
      int nd; int nb, nd2, da; logic [11:0] pr; logic bo, pm;
      nd = 0;
      @(negedge clk);
      a = 8'd200; b = 4'd13; c = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (p !== 12'd0) begin failures++; $display("FAIL midrst_p got=%0d exp=0", p); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (done) nd++;
         @(negedge clk);
      end
      checks++; if (nd != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", nd); end
      do_op(8'd3, 4'd5, 4'd2, nb, nd2, da, pr, bo, pm);
      checks++; if (pr !== 12'd17 || nd2 != 1) begin failures++; $display("FAIL midrst_next_p got=%0d dones=%0d exp=17 dones=1", pr, nd2); end
      $display("test_reset_mid_run: dones_after_abort=%0d next_p=%0d", nd, pr);
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ta [3] = '{8'd10, 8'd255, 8'd16};
      logic [3:0]  tb [3] = '{4'd10, 4'd1, 4'd15};
      logic [3:0]  tc [3] = '{4'd1, 4'd0, 4'd15};
      logic [11:0] te [3] = '{12'd101, 12'd255, 12'd255};
      int at [3];
      int n;
      n = 0;
      @(negedge clk);
      a = ta[0]; b = tb[0]; c = tc[0]; start = 1'b1;
      for (int k = 0; k < 40 && n < 3; k++) begin
         @(negedge clk);
         if (done) begin
            checks++; if (p !== te[n]) begin failures++; $display("FAIL b2b_p[%0d] got=%0d exp=%0d", n, p, te[n]); end
            at[n] = k;
            $display("test_back_to_back: op%0d p=%0d at_cycle=%0d", n, p, k);
            n++;
            if (n < 3) begin a = ta[n]; b = tb[n]; c = tc[n]; end
            else start = 1'b0;
         end
      end
      start = 1'b0;
      checks++;
      if (n != 3) begin
         failures++; $display("FAIL b2b_count got=%0d exp=3", n);
      end else if (at[1] - at[0] != 6 || at[2] - at[1] != 6) begin
         failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=6,6", at[1] - at[0], at[2] - at[1]);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_round_trip();
      int bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         int dividend, divisor, got_done;
         dividend = int'($urandom_range(0, 4095));
         divisor  = int'($urandom_range(1, 15));
         @(negedge clk);
         a2 = 12'(dividend / divisor); b2 = 4'(divisor); c2 = 4'(dividend % divisor);
         start2 = 1'b1;
         @(negedge clk);
         start2 = 1'b0;
         got_done = 0;
         for (int k = 0; k < 10 && got_done == 0; k++) begin
            if (done2) got_done = 1;
            else @(negedge clk);
         end
         checks++;
         if (got_done == 0 || p2 !== 16'(dividend)) begin
            failures++; bad++;
            $display("FAIL round_trip[%0d] got=%0d done=%0d exp=%0d (div=%0d)", i, p2, got_done, dividend, divisor);
         end
      end
      $display("test_round_trip: 1000 vectors, bad=%0d", bad);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      test_round_trip();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
